// File: rtl/rtc_bus_writer_if.sv
// Handshake and multiplexed AD-bus signals for the RTC write-side master.
// The master modport is the writer; the slave modport is the requester/bus side.
interface rtc_bus_writer_if;
  logic       start;
  logic [8:0] wmask;
  logic [7:0] hora;
  logic [7:0] min;
  logic [7:0] seg;
  logic [7:0] dia;
  logic [7:0] mes;
  logic [7:0] year;
  logic [7:0] horacrono;
  logic [7:0] mincrono;
  logic [7:0] segcrono;
  logic       AmPm;
  logic [7:0] ADout;
  logic       bus_oe;
  logic       ctrl_oe;
  logic       ad;
  logic       wr;
  logic       rd;
  logic       cs;
  logic       busy;
  logic       done;

  modport master (
    input  start, wmask, hora, min, seg, dia, mes, year,
           horacrono, mincrono, segcrono, AmPm,
    output ADout, bus_oe, ctrl_oe, ad, wr, rd, cs, busy, done
  );

  modport slave (
    output start, wmask, hora, min, seg, dia, mes, year,
           horacrono, mincrono, segcrono, AmPm,
    input  ADout, bus_oe, ctrl_oe, ad, wr, rd, cs, busy, done
  );
endinterface

// File: rtl/rtc_bus_writer.sv
// Write-side master for the multiplexed address/data RTC bus: snapshots the
// time/date/chrono fields on start and writes each selected one, then an optional commit.
module rtc_bus_writer #(
  parameter bit         COMMIT_EN   = 1'b1,
  parameter logic [7:0] COMMIT_ADDR = 8'hF1,
  parameter logic [7:0] COMMIT_DATA = 8'h00
) (
  input  logic             clock,
  input  logic             reset,
  rtc_bus_writer_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_XFER, S_COMMIT, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [5:0] cont_q, cont_d;
  logic       wrote_q, wrote_d;
  logic [8:0] mask_q, mask_d;
  logic [7:0] snap_q [9];
  logic [7:0] snap_d [9];
  logic [7:0] adout_q, adout_d;
  logic       bus_oe_q, bus_oe_d;
  logic       ctrl_oe_q, ctrl_oe_d;
  logic       ad_q, ad_d, wr_q, wr_d, rd_q, rd_d, cs_q, cs_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] cur_addr, cur_data;

  // Register address and data byte for the write currently in flight.
  always_comb begin
    cur_addr = 8'h00;
    cur_data = 8'h00;
    if (state_q == S_COMMIT) begin
      cur_addr = COMMIT_ADDR;
      cur_data = COMMIT_DATA;
    end else begin
      case (idx_q)
        4'd0: cur_addr = 8'h26;
        4'd1: cur_addr = 8'h25;
        4'd2: cur_addr = 8'h24;
        4'd3: cur_addr = 8'h23;
        4'd4: cur_addr = 8'h22;
        4'd5: cur_addr = 8'h21;
        4'd6: cur_addr = 8'h43;
        4'd7: cur_addr = 8'h42;
        4'd8: cur_addr = 8'h41;
        default: cur_addr = 8'h00;
      endcase
      if (idx_q <= 4'd8) cur_data = snap_q[idx_q];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cont_d    = cont_q;
    wrote_d   = wrote_q;
    mask_d    = mask_q;
    snap_d    = snap_q;
    adout_d   = adout_q;
    bus_oe_d  = bus_oe_q;
    ctrl_oe_d = ctrl_oe_q;
    ad_d      = ad_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // The hour byte carries AmPm in bit 7 in place of hora[7].
          snap_d[0] = bus.year;
          snap_d[1] = bus.mes;
          snap_d[2] = bus.dia;
          snap_d[3] = {bus.AmPm, bus.hora[6:0]};
          snap_d[4] = bus.min;
          snap_d[5] = bus.seg;
          snap_d[6] = bus.horacrono;
          snap_d[7] = bus.mincrono;
          snap_d[8] = bus.segcrono;
          mask_d    = bus.wmask;
          wrote_d   = 1'b0;
          idx_d     = 4'd0;
          busy_d    = 1'b1;
          ctrl_oe_d = 1'b1;
          state_d   = S_SEL;
        end
      end
      S_SEL: begin
        if (idx_q <= 4'd8) begin
          if (mask_q[idx_q]) begin
            cont_d  = 6'd0;
            state_d = S_XFER;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (COMMIT_EN && wrote_q) begin
          cont_d  = 6'd0;
          state_d = S_COMMIT;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_XFER, S_COMMIT: begin
        cont_d = cont_q + 6'd1;
        case (cont_q)
          6'd0: begin
            ad_d     = 1'b1;
            wr_d     = 1'b1;
            rd_d     = 1'b1;
            cs_d     = 1'b1;
            bus_oe_d = 1'b0;
          end
          6'd1:  ad_d = 1'b0;
          6'd2:  cs_d = 1'b0;
          6'd3:  wr_d = 1'b0;
          6'd5: begin
            adout_d  = cur_addr;
            bus_oe_d = 1'b1;
          end
          6'd8:  wr_d = 1'b1;
          6'd9:  cs_d = 1'b1;
          6'd10: ad_d = 1'b1;
          6'd12: bus_oe_d = 1'b0;
          6'd15: cs_d = 1'b0;
          6'd16: wr_d = 1'b0;
          6'd17: begin
            adout_d  = cur_data;
            bus_oe_d = 1'b1;
          end
          6'd21: wr_d = 1'b1;
          6'd22: cs_d = 1'b1;
          6'd24: begin
            bus_oe_d = 1'b0;
            adout_d  = 8'h00;
          end
          6'd31: begin
            cont_d = 6'd0;
            if (state_q == S_XFER) begin
              wrote_d = 1'b1;
              idx_d   = idx_q + 4'd1;
              state_d = S_SEL;
            end else begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
          default: ;
        endcase
      end
      S_DONE: begin
        busy_d    = 1'b0;
        ctrl_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      cont_q    <= 6'd0;
      wrote_q   <= 1'b0;
      mask_q    <= 9'd0;
      snap_q    <= '{default: 8'h00};
      adout_q   <= 8'h00;
      bus_oe_q  <= 1'b0;
      ctrl_oe_q <= 1'b0;
      ad_q      <= 1'b1;
      wr_q      <= 1'b1;
      rd_q      <= 1'b1;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cont_q    <= cont_d;
      wrote_q   <= wrote_d;
      mask_q    <= mask_d;
      snap_q    <= snap_d;
      adout_q   <= adout_d;
      bus_oe_q  <= bus_oe_d;
      ctrl_oe_q <= ctrl_oe_d;
      ad_q      <= ad_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.ADout   = adout_q;
  assign bus.bus_oe  = bus_oe_q;
  assign bus.ctrl_oe = ctrl_oe_q;
  assign bus.ad      = ad_q;
  assign bus.wr      = wr_q;
  assign bus.rd      = rd_q;
  assign bus.cs      = cs_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: doc/rtc_bus_writer.md
Name: rtc_bus_writer

Overview:
- Write-side master for the multiplexed address/data RTC bus that the time-reader block polls.
- On a start pulse it snapshots the time, date and chrono fields, then writes each selected field into its RTC register.
- Each register write is an address-latch phase followed by a data-write phase. An optional commit/transfer write follows the last field.
- Sits beside the reader; top level muxes the bus using ctrl_oe/bus_oe. It never drives rd low.

Parameters:
COMMIT_EN, 1, 1 = issue commit write after at least one field write; 0 = never
COMMIT_ADDR, 8'hF1, register address of the commit/transfer command
COMMIT_DATA, 8'h00, data byte written during commit

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
wmask  in  9  field select: bit0 year, 1 mes, 2 dia, 3 hora, 4 min, 5 seg, 6 horacrono, 7 mincrono, 8 segcrono
hora, min, seg, dia, mes, year, horacrono, mincrono, segcrono  in  8 each  field values
AmPm  in  1  merged into the hour byte
ADout  out  8  address/data byte to the bus
bus_oe  out  1  1 = ADout must drive the AD pins
ctrl_oe  out  1  1 = this block owns ad/wr/rd/cs
ad, wr, rd, cs  out  1 each  bus strobes, all active-low
busy  out  1  high from start acceptance until the done cycle inclusive
done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset (async) and IDLE values: ad=wr=rd=cs=1, ADout=8'h00, bus_oe=0, ctrl_oe=0, busy=0, done=0, idx=0, cont=0, wrote=0.
- Start acceptance:
  - start high in IDLE at edge E0 snapshots all field inputs, AmPm and wmask, and clears wrote.
  - From E0: busy=1, ctrl_oe=1, state=SEL, idx=0.
  - start while busy is ignored; changes to field inputs after E0 are ignored.
- Address map by idx 0..8: 0x26, 0x25, 0x24, 0x23, 0x22, 0x21, 0x43, 0x42, 0x41.
- Hour byte is {AmPm, hora[6:0]}; hora[7] is discarded. All other data bytes are the snapshot value unchanged.
- SEL state (1 cycle):
  - idx<=8 and mask[idx]=1: go XFER, cont=0.
  - idx<=8 and mask[idx]=0: idx+1, stay SEL; no strobe activity.
  - idx==9: go COMMIT (cont=0) if COMMIT_EN and wrote=1, else DONE.
- XFER/COMMIT state, 6-bit cont running 0..31; actions take effect at the edge ending that cont value:
  - 0: ad=wr=rd=cs=1, bus_oe=0
  - 1: ad=0
  - 2: cs=0
  - 3: wr=0
  - 5: ADout=address, bus_oe=1
  - 8: wr=1 (address latched)
  - 9: cs=1
  - 10: ad=1
  - 12: bus_oe=0
  - 15: cs=0
  - 16: wr=0
  - 17: ADout=data, bus_oe=1
  - 21: wr=1 (data written)
  - 22: cs=1
  - 24: bus_oe=0, ADout=8'h00
  - 31: XFER sets wrote=1, idx+1 and returns to SEL; COMMIT goes to DONE
- One register write is exactly 32 cycles. rd stays 1 throughout.
- ADout is stable whenever wr rises and whenever bus_oe=1.
- DONE state (1 cycle): done=1, busy=1. Next edge: done=0, busy=0, ctrl_oe=0, state=IDLE. A start in that same edge is accepted only from IDLE, i.e. one cycle later.
- wmask=0: walks 10 SEL cycles, then DONE, no strobe edges, no commit.
- Reset mid-transfer: all strobes return to 1 immediately and the block goes to IDLE. A partial write is abandoned; there is no retry.

Test Plan:
- Reset during XFER cont=17 -> ad/wr/cs=1, bus_oe=0, ctrl_oe=0, busy=0 without waiting for a clock edge; the next start runs a full sequence.
- wmask=9'h020, seg=8'h59, COMMIT_EN=1 -> two transactions:
  - address 0x21 / data 0x59, then 0xF1 / 0x00; rd never low.
  - busy high for 6+32+4+32+1=75 cycles; done on the last of them.
- wmask=9'h008, hora=8'h91, AmPm=1 -> address 0x23 latched on the wr rise at cont 8; data byte 8'h91; commit follows.
- wmask=9'h1FF with known values -> addresses in order 26, 25, 24, 23, 22, 21, 43, 42, 41, F1; each data byte matches the snapshot even when inputs change 1 cycle after start.
- wmask=0 -> no cs/wr activity; done pulse 11 cycles after start is accepted.
- start reasserted at cont=5 of the first XFER -> ignored; exactly one sequence is performed.
